// File: rtl/dp_req_queue.sv
// Request queue and response tagger between the core-side mem port and the mem2dp bridge.
// Optional response timeout with error reply and drain is enabled by defining DP_TIMEOUT_EN.

package dp_req_pkg;

  typedef struct packed {
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        req_type;   // 0 = read, 1 = write
    logic [3:0]  req_tid;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] resp_data;
    logic        resp_type;
    logic [3:0]  resp_tid;
  } mem_resp_t;

endpackage

module dp_req_queue
  import dp_req_pkg::*;
#(
  parameter int REQ_DEPTH = 4,
  parameter int TO_W      = 16,
  parameter int TO_CYC    = 1000
) (
  input  logic      dp_clk_i,
  input  logic      dp_rstn_i,
  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // a source holds valid and payload stable until that edge.
  input  logic      s_mem_req_valid,
  output logic      s_mem_req_ready,
  input  mem_req_t  s_mem_req,
  output logic      s_mem_resp_valid,
  input  logic      s_mem_resp_ready,
  output mem_resp_t s_mem_resp,
  output logic      s_resp_err,
  output logic      m_mem_req_valid,
  input  logic      m_mem_req_ready,
  output mem_req_t  m_mem_req,
  input  logic      m_mem_resp_valid,
  output logic      m_mem_resp_ready,
  input  mem_resp_t m_mem_resp,
  output logic [2:0] dbg_state_o
);

  localparam int AW = $clog2(REQ_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3
`ifdef DP_TIMEOUT_EN
    ,
    ST_RESP_ERR = 3'd4,
    ST_DRAIN    = 3'd5
`endif
  } state_e;

  state_e      state_q, state_d;
  mem_req_t    fifo_q [REQ_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        req_ready_q;
  logic [31:0] data_q, data_d;
  logic [3:0]  tid_q, tid_d;
  logic        type_q, type_d;
  logic        fifo_empty;
  logic        push;
  logic        pop;

  function automatic logic is_full(input logic [AW:0] wp, input logic [AW:0] rp);
    return (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  endfunction

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign push       = s_mem_req_valid & req_ready_q;
  assign pop        = (state_q == ST_ISSUE) & m_mem_req_ready & ~fifo_empty;
  assign wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

  // Ready is registered from the next pointers so it is 0 in reset and rises one clock after release.
  always_ff @(posedge dp_clk_i or negedge dp_rstn_i) begin
    if (!dp_rstn_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      req_ready_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      req_ready_q <= ~is_full(wr_ptr_d, rd_ptr_d);
    end
  end

  always_ff @(posedge dp_clk_i) begin
    if (push) begin
      fifo_q[wr_ptr_q[AW-1:0]] <= s_mem_req;
    end
  end

`ifdef DP_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  always_ff @(posedge dp_clk_i or negedge dp_rstn_i) begin
    if (!dp_rstn_i) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  logic [TO_W-1:0] unused_to;
  assign unused_to = TO_W'(TO_CYC);
`endif

  logic unused_resp;
  assign unused_resp = ^{m_mem_resp.resp_type, m_mem_resp.resp_tid};

  always_ff @(posedge dp_clk_i or negedge dp_rstn_i) begin
    if (!dp_rstn_i) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      tid_q   <= '0;
      type_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      tid_q   <= tid_d;
      type_q  <= type_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    tid_d    = tid_q;
    type_d   = type_q;
`ifdef DP_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (pop) begin
          tid_d   = m_mem_req.req_tid;
          type_d  = m_mem_req.req_type;
          state_d = ST_WAIT;
`ifdef DP_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end
      end
      ST_WAIT: begin
        // A response arriving on the timeout cycle takes priority over the error.
        if (m_mem_resp_valid) begin
          data_d  = m_mem_resp.resp_data;
          state_d = ST_RESP;
        end
`ifdef DP_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          data_d  = 32'hDEAD_BEEF;
          state_d = ST_RESP_ERR;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end
      ST_RESP: begin
        if (s_mem_resp_ready) state_d = fifo_empty ? ST_IDLE : ST_ISSUE;
      end
`ifdef DP_TIMEOUT_EN
      ST_RESP_ERR: begin
        if (s_mem_resp_ready) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (m_mem_resp_valid) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  assign s_mem_req_ready  = req_ready_q;
  assign m_mem_req_valid  = (state_q == ST_ISSUE);
  assign m_mem_req        = fifo_q[rd_ptr_q[AW-1:0]];
  assign s_mem_resp       = '{resp_data: data_q, resp_type: type_q, resp_tid: tid_q};
  assign dbg_state_o      = state_q;
`ifdef DP_TIMEOUT_EN
  assign m_mem_resp_ready = (state_q == ST_WAIT) || (state_q == ST_DRAIN);
  assign s_mem_resp_valid = (state_q == ST_RESP) || (state_q == ST_RESP_ERR);
  assign s_resp_err       = (state_q == ST_RESP_ERR);
`else
  assign m_mem_resp_ready = (state_q == ST_WAIT);
  assign s_mem_resp_valid = (state_q == ST_RESP);
  assign s_resp_err       = 1'b0;
`endif

endmodule

// File: tb/tb_dp_req_queue.sv
// Directed bench for dp_req_queue: reset, single read, full queue, response backpressure,
// mid-operation reset, and (with DP_TIMEOUT_EN) the timeout/drain paths.

module tb_dp_req_queue;
  import dp_req_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       s_mem_req_valid;
  logic       s_mem_req_ready;
  mem_req_t   s_mem_req;
  logic       s_mem_resp_valid;
  logic       s_mem_resp_ready;
  mem_resp_t  s_mem_resp;
  logic       s_resp_err;
  logic       m_mem_req_valid;
  logic       m_mem_req_ready;
  mem_req_t   m_mem_req;
  logic       m_mem_resp_valid;
  logic       m_mem_resp_ready;
  mem_resp_t  m_mem_resp;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;

  dp_req_queue #(.REQ_DEPTH(4), .TO_W(16), .TO_CYC(8)) dut (
    .dp_clk_i         (clk),
    .dp_rstn_i        (rst_n),
    .s_mem_req_valid  (s_mem_req_valid),
    .s_mem_req_ready  (s_mem_req_ready),
    .s_mem_req        (s_mem_req),
    .s_mem_resp_valid (s_mem_resp_valid),
    .s_mem_resp_ready (s_mem_resp_ready),
    .s_mem_resp       (s_mem_resp),
    .s_resp_err       (s_resp_err),
    .m_mem_req_valid  (m_mem_req_valid),
    .m_mem_req_ready  (m_mem_req_ready),
    .m_mem_req        (m_mem_req),
    .m_mem_resp_valid (m_mem_resp_valid),
    .m_mem_resp_ready (m_mem_resp_ready),
    .m_mem_resp       (m_mem_resp),
    .dbg_state_o      (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  function automatic mem_req_t mk_req(input logic [3:0] tid, input logic [31:0] addr, input logic typ);
    mem_req_t r;
    r.req_addr  = addr;
    r.req_wdata = {addr[15:0], 12'h0, tid};
    r.req_be    = 4'hF;
    r.req_type  = typ;
    r.req_tid   = tid;
    return r;
  endfunction

  task automatic push(input logic [3:0] tid, input logic [31:0] addr, input logic typ);
    int n = 0;
    while (!s_mem_req_ready && n < 100) begin
      tick();
      n++;
    end
    chk("push_ready", {63'b0, s_mem_req_ready}, 64'd1);
    s_mem_req_valid = 1'b1;
    s_mem_req       = mk_req(tid, addr, typ);
    tick();
    s_mem_req_valid = 1'b0;
  endtask

  task automatic issue_accept(input logic [3:0] tid);
    int n = 0;
    while (!m_mem_req_valid && n < 100) begin
      tick();
      n++;
    end
    chk("issue_valid", {63'b0, m_mem_req_valid}, 64'd1);
    chk("issue_tid", {60'b0, m_mem_req.req_tid}, {60'b0, tid});
    m_mem_req_ready = 1'b1;
    tick();
    m_mem_req_ready = 1'b0;
    chk("single_outstanding", {63'b0, m_mem_req_valid}, 64'd0);
  endtask

  task automatic respond(input logic [31:0] data);
    m_mem_resp_valid = 1'b1;
    m_mem_resp      = '{resp_data: data, resp_type: 1'b1, resp_tid: 4'hF};
    tick();
    m_mem_resp_valid = 1'b0;
    m_mem_resp      = '0;
  endtask

  task automatic check_resp(input logic [3:0] tid, input logic typ, input logic [31:0] data,
                            input logic err);
    chk("resp_valid", {63'b0, s_mem_resp_valid}, 64'd1);
    chk("resp_data", {32'b0, s_mem_resp.resp_data}, {32'b0, data});
    chk("resp_tid", {60'b0, s_mem_resp.resp_tid}, {60'b0, tid});
    chk("resp_type", {63'b0, s_mem_resp.resp_type}, {63'b0, typ});
    chk("resp_err", {63'b0, s_resp_err}, {63'b0, err});
  endtask

  task automatic accept_resp();
    s_mem_resp_ready = 1'b1;
    tick();
    s_mem_resp_ready = 1'b0;
  endtask

  initial begin
    rst_n            = 1'b0;
    s_mem_req_valid  = 1'b0;
    s_mem_req        = '0;
    s_mem_resp_ready = 1'b0;
    m_mem_req_ready  = 1'b0;
    m_mem_resp_valid = 1'b0;
    m_mem_resp       = '0;
    repeat (3) tick();

    // Reset state
    chk("rst_req_ready", {63'b0, s_mem_req_ready}, 64'd0);
    chk("rst_m_req_valid", {63'b0, m_mem_req_valid}, 64'd0);
    chk("rst_m_resp_ready", {63'b0, m_mem_resp_ready}, 64'd0);
    chk("rst_s_resp_valid", {63'b0, s_mem_resp_valid}, 64'd0);
    chk("rst_s_resp", {23'b0, s_mem_resp}, 64'd0);
    chk("rst_err", {63'b0, s_resp_err}, 64'd0);
    rst_n = 1'b1;
    chk("rel_req_ready_before_clk", {63'b0, s_mem_req_ready}, 64'd0);
    tick();
    chk("rel_req_ready_after_clk", {63'b0, s_mem_req_ready}, 64'd1);

    // Single read, tid 3, answered after 40 cycles; check the two-cycle issue latency
    s_mem_req_valid = 1'b1;
    s_mem_req       = mk_req(4'd3, 32'h100, 1'b0);
    tick();
    s_mem_req_valid = 1'b0;
    chk("lat_push_cycle", {63'b0, m_mem_req_valid}, 64'd0);
    tick();
    chk("lat_issue_valid", {63'b0, m_mem_req_valid}, 64'd1);
    chk("lat_issue_addr", {32'b0, m_mem_req.req_addr}, 64'h100);
    issue_accept(4'd3);
    repeat (40) tick();
    chk("wait_no_resp", {63'b0, s_mem_resp_valid}, 64'd0);
    chk("wait_resp_ready", {63'b0, m_mem_resp_ready}, 64'd1);
    respond(32'h1234_5678);
    check_resp(4'd3, 1'b0, 32'h1234_5678, 1'b0);
    accept_resp();
    chk("t1_idle", {61'b0, dbg_state}, 64'd0);
    chk("t1_resp_gone", {63'b0, s_mem_resp_valid}, 64'd0);

    // Five back-to-back pushes with the bridge stalled; fifth waits for space
    s_mem_req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_mem_req = mk_req(4'(i), 32'h200 + 32'(i * 4), 1'b0);
      tick();
    end
    chk("t2_full_ready", {63'b0, s_mem_req_ready}, 64'd0);
    s_mem_req = mk_req(4'd4, 32'h210, 1'b0);
    issue_accept(4'd0);
    respond(32'hA0);
    s_mem_req_valid = 1'b0;
    check_resp(4'd0, 1'b0, 32'hA0, 1'b0);
    chk("t2_full_again", {63'b0, s_mem_req_ready}, 64'd0);
    accept_resp();
    for (int k = 1; k < 5; k++) begin
      issue_accept(4'(k));
      respond(32'hA0 + 32'(k));
      check_resp(4'(k), 1'b0, 32'hA0 + 32'(k), 1'b0);
      accept_resp();
    end
    tick();
    chk("t2_empty_idle", {61'b0, dbg_state}, 64'd0);
    chk("t2_ready_back", {63'b0, s_mem_req_ready}, 64'd1);

    // Response held for 10 cycles with another request queued behind it
    push(4'd5, 32'h300, 1'b1);
    push(4'd6, 32'h304, 1'b0);
    issue_accept(4'd5);
    respond(32'hBEEF_0005);
    for (int i = 0; i < 10; i++) begin
      check_resp(4'd5, 1'b1, 32'hBEEF_0005, 1'b0);
      chk("t3_no_issue", {63'b0, m_mem_req_valid}, 64'd0);
      tick();
    end
    accept_resp();
    chk("t3_back_to_back", {63'b0, m_mem_req_valid}, 64'd1);
    issue_accept(4'd6);
    respond(32'hBEEF_0006);
    check_resp(4'd6, 1'b0, 32'hBEEF_0006, 1'b0);
    accept_resp();

`ifdef DP_TIMEOUT_EN
    // Silent bridge: error reply 8 cycles after WAIT entry, late response drained
    push(4'd7, 32'h400, 1'b0);
    issue_accept(4'd7);
    repeat (7) tick();
    chk("to_not_yet", {63'b0, s_mem_resp_valid}, 64'd0);
    tick();
    check_resp(4'd7, 1'b0, 32'hDEAD_BEEF, 1'b1);
    push(4'd8, 32'h404, 1'b0);
    accept_resp();
    repeat (3) tick();
    chk("drain_no_issue", {63'b0, m_mem_req_valid}, 64'd0);
    chk("drain_resp_ready", {63'b0, m_mem_resp_ready}, 64'd1);
    respond(32'h5555_5555);
    chk("drain_not_forwarded", {63'b0, s_mem_resp_valid}, 64'd0);
    issue_accept(4'd8);
    respond(32'h0000_0808);
    check_resp(4'd8, 1'b0, 32'h0000_0808, 1'b0);
    accept_resp();

    // Response on the timeout cycle wins
    push(4'd9, 32'h500, 1'b1);
    issue_accept(4'd9);
    repeat (7) tick();
    respond(32'h0000_0909);
    check_resp(4'd9, 1'b1, 32'h0000_0909, 1'b0);
    accept_resp();
`endif

    // Reset during WAIT with two requests still queued
    push(4'd1, 32'h600, 1'b0);
    push(4'd2, 32'h604, 1'b0);
    push(4'd3, 32'h608, 1'b0);
    issue_accept(4'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_m_req_valid", {63'b0, m_mem_req_valid}, 64'd0);
    chk("mrst_m_resp_ready", {63'b0, m_mem_resp_ready}, 64'd0);
    chk("mrst_s_resp_valid", {63'b0, s_mem_resp_valid}, 64'd0);
    chk("mrst_req_ready", {63'b0, s_mem_req_ready}, 64'd0);
    tick();
    rst_n = 1'b1;
    m_mem_resp_valid = 1'b1;
    m_mem_resp       = '{resp_data: 32'h0BAD_0BAD, resp_type: 1'b0, resp_tid: 4'd1};
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("mrst_no_resp", {63'b0, s_mem_resp_valid}, 64'd0);
      chk("mrst_no_issue", {63'b0, m_mem_req_valid}, 64'd0);
    end
    m_mem_resp_valid = 1'b0;
    chk("mrst_idle", {61'b0, dbg_state}, 64'd0);
    chk("mrst_ready", {63'b0, s_mem_req_ready}, 64'd1);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
